// File: rtl/imem_pkg.sv
// imem_pkg
//   Shared types and constants for the instruction-memory fetch unit.
//   fault_e : response fault codes carried on rsp_fault.
//   state_e : fetch/load controller states (RUN, DRAIN, LOAD).
//   NOP     : default instruction word substituted on any fault.
package imem_pkg;

  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10,
    FLT_PARITY   = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_fetch_unit_if.sv
// imem_fetch_unit_if
//   Bundles the fetch request/response handshake and the program-load port
//   of imem_fetch_unit.
//   Optional macro: IMEM_PARITY_EN adds ld_par_inv (parity error injection).
//
//   Handshake rules (both req_* and rsp_* channels):
//     - A transfer happens on a rising edge where valid && ready are both 1.
//     - The producer keeps valid and its payload stable until the transfer.
//     - ready may depend combinationally on the consumer's state but never on
//       the producer's valid.
//
//   master : the fetch stage / loader side (drives req_*, rsp_ready, ld_*).
//   slave  : imem_fetch_unit side.
interface imem_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_instr;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_fault;
  logic              ld_en;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic [3:0]        ld_be;
`ifdef IMEM_PARITY_EN
  logic              ld_par_inv;

  modport master (
    output req_valid, req_addr, rsp_ready,
    output ld_en, ld_we, ld_addr, ld_data, ld_be, ld_par_inv,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    input  ld_en, ld_we, ld_addr, ld_data, ld_be, ld_par_inv,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
`else
  modport master (
    output req_valid, req_addr, rsp_ready,
    output ld_en, ld_we, ld_addr, ld_data, ld_be,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    input  ld_en, ld_we, ld_addr, ld_data, ld_be,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
`endif

endinterface

// File: rtl/imem_byte_array.sv
// imem_byte_array
//   Byte-organised storage with a word-wide synchronous read and a
//   byte-enabled synchronous write. Both ports address whole words.
//   Optional macro: IMEM_PARITY_EN keeps one even-parity bit per byte.
//
//   clk, rst_n  : clock; rst_n only clears the read register, never storage
//   rd_en       : capture word rd_widx into rd_data on the next edge
//   rd_widx     : read word index
//   rd_data     : little-endian word, holds until the next rd_en
//   rd_par_err  : (macro) any byte of the captured word failed parity
//   wr_en       : write strobe
//   wr_widx     : write word index
//   wr_data     : little-endian write data
//   wr_be       : bit i writes byte 4*wr_widx+i
//   wr_par_inv  : (macro) store inverted parity for the written bytes
module imem_byte_array #(
  parameter  int DEPTH_BYTES = 256,
  localparam int AW          = $clog2(DEPTH_BYTES),
  localparam int WW          = AW - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [WW-1:0] rd_widx,
  output logic [31:0]   rd_data,
`ifdef IMEM_PARITY_EN
  output logic          rd_par_err,
  input  logic          wr_par_inv,
`endif
  input  logic          wr_en,
  input  logic [WW-1:0] wr_widx,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be
);

  // Storage powers up as all zeros; it is deliberately outside reset.
  logic [7:0]  mem_q [DEPTH_BYTES] = '{default: 8'h00};
  logic [31:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      for (int i = 0; i < 4; i++) begin
        rd_data_d[8*i +: 8] = mem_q[{rd_widx, 2'(i)}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[{wr_widx, 2'(i)}] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= 32'h0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

`ifdef IMEM_PARITY_EN
  // Zero bytes have even parity 0, so the zero default is self-consistent.
  logic par_q [DEPTH_BYTES] = '{default: 1'b0};
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (rd_en) begin
      par_err_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (par_q[{rd_widx, 2'(i)}] != ^mem_q[{rd_widx, 2'(i)}]) par_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) par_q[{wr_widx, 2'(i)}] <= (^wr_data[8*i +: 8]) ^ wr_par_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign rd_par_err = par_err_q;
`endif

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit
//   Instruction memory for the fetch stage: one-cycle registered read with a
//   valid/ready handshake, back-pressure hold, a runtime program-load port
//   and alignment/range (optionally parity) fault reporting.
//   Optional macro: IMEM_PARITY_EN (parity per byte, fault 11, ld_par_inv).
//
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : imem_fetch_unit_if.slave (req_*, rsp_*, ld_*)
//   busy      : high whenever the controller is not in RUN
//   state_dbg : current controller state (imem_pkg::state_e encoding)
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 256,
  parameter int          ADDR_W      = 64,
  parameter logic [31:0] NOP_INSTR   = NOP
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_fetch_unit_if.slave   bus,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam int AW = $clog2(DEPTH_BYTES);

  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_LOAD  = LOAD;

  localparam logic [1:0] F_OK       = FLT_OK;
  localparam logic [1:0] F_MISALIGN = FLT_MISALIGN;
  localparam logic [1:0] F_RANGE    = FLT_RANGE;

  logic [1:0]        state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [1:0]        fault_q, fault_d;

  logic              req_ready;
  logic              accept;
  logic              consume;
  logic [1:0]        req_fault;
  logic              rd_en;
  logic              wr_en;
  logic [31:0]       rd_data;
  logic [1:0]        rsp_fault;

  // Load word addresses ignore the byte offset.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^bus.ld_addr[1:0];

  assign req_ready = (state_q == ST_RUN) && !bus.ld_en && (!rsp_valid_q || bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;
  assign consume   = rsp_valid_q && bus.rsp_ready;

  // Misalignment wins over range. For an aligned address, "a > DEPTH-4"
  // reduces to any address bit at or above AW being set.
  always_comb begin
    req_fault = F_OK;
    if (bus.req_addr[1:0] != 2'b00)      req_fault = F_MISALIGN;
    else if (|bus.req_addr[ADDR_W-1:AW]) req_fault = F_RANGE;
  end

  // Storage is only read for fault-free fetches.
  assign rd_en = accept && (req_fault == F_OK);
  assign wr_en = (state_q == ST_LOAD) && bus.ld_we && !(|bus.ld_addr[ADDR_W-1:AW]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.ld_en) state_d = (rsp_valid_q && !bus.rsp_ready) ? ST_DRAIN : ST_LOAD;
      end
      ST_DRAIN: begin
        if (!bus.ld_en)   state_d = ST_RUN;
        else if (consume) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!bus.ld_en) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Response registers only move on acceptance or consumption, which gives
  // the hold-while-stalled behaviour for free.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    fault_d     = fault_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = bus.req_addr;
      fault_d     = req_fault;
    end else if (consume) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      fault_q     <= F_OK;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      fault_q     <= fault_d;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_err;
  localparam logic [1:0] F_PARITY = FLT_PARITY;

  // Parity is only known once the word has been read, so it is folded in
  // on the output side; address faults never read storage.
  assign rsp_fault = ((fault_q == F_OK) && par_err) ? F_PARITY : fault_q;
`else
  assign rsp_fault = fault_q;
`endif

  imem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_byte_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_widx    (bus.req_addr[AW-1:2]),
    .rd_data    (rd_data),
`ifdef IMEM_PARITY_EN
    .rd_par_err (par_err),
    .wr_par_inv (bus.ld_par_inv),
`endif
    .wr_en      (wr_en),
    .wr_widx    (bus.ld_addr[AW-1:2]),
    .wr_data    (bus.ld_data),
    .wr_be      (bus.ld_be)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_fault = rsp_fault;
  assign bus.rsp_instr = (rsp_fault != F_OK) ? NOP_INSTR : rd_data;

  assign busy      = (state_q != ST_RUN);
  assign state_dbg = state_q;

endmodule
